// File: rtl/gf163_reduce_seq.sv
// Sequential reduction of a 326-bit GF(2)[x] product modulo x^163 + x^7 + x^6 + x^3 + 1.
// Folds DIGIT high-order coefficients per clock, top-down, behind valid/ready handshakes.
module gf163_reduce_seq #(
  parameter int DIGIT = 27
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [325:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [162:0] c,
  output logic         busy
);

  // state  | meaning
  // S_IDLE | waiting for an operand, in_ready high
  // S_FOLD | folding one window of high coefficients per cycle
  // S_DONE | result held on c until the consumer takes it

  localparam int NFOLD = (162 + DIGIT - 1) / DIGIT;

  generate
    if ((DIGIT < 1) || (DIGIT > 155)) begin : g_bad_digit
      $error("gf163_reduce_seq: DIGIT must be in 1..155");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FOLD, S_DONE} state_t;

  state_t         state;
  logic [324:0]   acc;
  logic [324:0]   win;
  logic [324:0]   acc_nxt;
  logic [8:0]     ptr;
  logic [7:0]     cnt;
  logic           unused_d_msb;

  // bit 325 of the product is defined as zero
  assign unused_d_msb = d[325];

  // Window is acc[ptr : max(ptr-DIGIT+1, 163)]; folded bits land at most at ptr-156,
  // strictly below the window, so every window bit is folded from the pre-edge acc.
  always_comb begin
    win = '0;
    for (int i = 163; i < 325; i++) begin
      win[i] = acc[i] && (i <= int'(ptr)) && ((i + DIGIT) > int'(ptr));
    end
    acc_nxt = acc ^ win ^ (win >> 163) ^ (win >> 160) ^ (win >> 157) ^ (win >> 156);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      ptr       <= 9'd324;
      cnt       <= '0;
      out_valid <= 1'b0;
      c         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc   <= d[324:0];
            ptr   <= 9'd324;
            cnt   <= '0;
            state <= S_FOLD;
          end
        end
        S_FOLD: begin
          acc <= acc_nxt;
          ptr <= ptr - 9'(DIGIT);
          cnt <= cnt + 8'd1;
          if (cnt == 8'(NFOLD - 1)) begin
            c         <= acc_nxt[162:0];
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_gf163_reduce_seq.sv
// Bench for gf163_reduce_seq: three instances (DIGIT = 1, 27, 155) share stimulus and are
// checked against a long-division polynomial remainder model.
module tb_gf163_reduce_seq;

  localparam int NI = 3;
  localparam logic [325:0] F_POLY = (326'd1 << 163) | 326'hC9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [325:0]   d;
  logic           out_ready;
  logic [NI-1:0]  in_ready;
  logic [NI-1:0]  out_valid;
  logic [NI-1:0]  busy;
  logic [162:0]   c [NI];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [325:0] dv;
    logic [162:0] cv;
  } vec_t;

  vec_t tbl [8];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      gf163_reduce_seq #(.DIGIT((g == 0) ? 1 : ((g == 1) ? 27 : 155))) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready[g]),
        .d         (d),
        .out_valid (out_valid[g]),
        .out_ready (out_ready),
        .c         (c[g]),
        .busy      (busy[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  function automatic int nfold_of(input int i);
    case (i)
      0:       return 162;
      1:       return 6;
      default: return 2;
    endcase
  endfunction

  function automatic logic [162:0] ref_mod(input logic [325:0] x);
    logic [325:0] r;
    r = x;
    r[325] = 1'b0;
    for (int i = 324; i >= 163; i--) begin
      if (r[i]) r = r ^ (F_POLY << (i - 163));
    end
    return r[162:0];
  endfunction

  function automatic logic [325:0] clmul(input logic [162:0] a, input logic [162:0] b);
    logic [325:0] p;
    p = '0;
    for (int i = 0; i < 163; i++) begin
      if (b[i]) p = p ^ ({163'd0, a} << i);
    end
    return p;
  endfunction

  function automatic logic [325:0] rand_wide();
    logic [351:0] t;
    for (int j = 0; j < 11; j++) t[j*32 +: 32] = $urandom();
    return t[325:0];
  endfunction

  task automatic chk(input string name, input logic [162:0] act, input logic [162:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One operation on all instances; checks result, latency, hold under back-pressure.
  task automatic run_op(input logic [325:0] dv, input logic [162:0] exp, input bit rnd_ready);
    int            cyc;
    bit            seen [NI];
    bit            fin  [NI];
    bit            all_fin;
    logic [NI-1:0] hs;
    logic [NI-1:0] fin_vec;
    cyc = 0;
    while (in_ready != '1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("idle_wait", 163'(in_ready), 163'(3'b111));
    d         = dv;
    in_valid  = 1'b1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    d        = rand_wide();
    chk("accept_busy", 163'(busy), 163'(3'b111));
    for (int i = 0; i < NI; i++) begin
      seen[i] = 1'b0;
      fin[i]  = 1'b0;
    end
    cyc     = 0;
    all_fin = 1'b0;
    while (!all_fin && cyc < 400) begin
      hs = out_valid & {NI{out_ready}};
      @(posedge clk); #1;
      cyc++;
      all_fin = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (hs[i] && !fin[i]) begin
          fin[i] = 1'b1;
          chk($sformatf("ov_clear_%0d", i), 163'(out_valid[i]), 163'd0);
          chk($sformatf("c_after_hs_%0d", i), c[i], exp);
        end else if (!seen[i] && out_valid[i]) begin
          seen[i] = 1'b1;
          chk($sformatf("latency_%0d", i), 163'(cyc), 163'(nfold_of(i)));
          chk($sformatf("result_%0d", i), c[i], exp);
        end else if (seen[i] && !fin[i]) begin
          chk($sformatf("ov_held_%0d", i), 163'(out_valid[i]), 163'd1);
        end
        if (!fin[i]) all_fin = 1'b0;
      end
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
    if (!all_fin) begin
      for (int i = 0; i < NI; i++) fin_vec[i] = fin[i];
      chk("op_timeout", 163'(fin_vec), 163'(3'b111));
    end
  endtask

  initial begin
    logic [325:0] x;
    logic [162:0] a;
    logic [162:0] b;
    logic [NI-1:0] stale;
    int            cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    d         = '0;
    out_ready = 1'b0;
    #12;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_ov_%0d", i), 163'(out_valid[i]), 163'd0);
      chk($sformatf("rst_c_%0d", i), c[i], 163'd0);
      chk($sformatf("rst_in_ready_%0d", i), 163'(in_ready[i]), 163'd1);
      chk($sformatf("rst_busy_%0d", i), 163'(busy[i]), 163'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{326'd1, 163'd1};
    tbl[1] = '{326'd1 << 163, 163'hC9};
    tbl[2] = '{326'd1 << 324, (163'd1 << 161) | 163'h1422};
    tbl[3] = '{326'd1 << 325, 163'd0};
    tbl[4] = '{(326'd1 << 325) | 326'd1, 163'd1};
    tbl[5] = '{326'd0, 163'd0};
    tbl[6] = '{326'd1 << 162, 163'd1 << 162};
    tbl[7] = '{{163'd0, {163{1'b1}}}, {163{1'b1}}};
    for (int k = 0; k < 8; k++) run_op(tbl[k].dv, tbl[k].cv, 1'b0);

    // back-pressure with ignored operands while in DONE
    d         = 326'd1 << 163;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid != '1 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_all_done", 163'(out_valid), 163'(3'b111));
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      d        = 326'd1;
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("bp_c_%0d", i), c[i], 163'hC9);
        chk($sformatf("bp_ov_%0d", i), 163'(out_valid[i]), 163'd1);
        chk($sformatf("bp_in_ready_%0d", i), 163'(in_ready[i]), 163'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("bp_rel_ov_%0d", i), 163'(out_valid[i]), 163'd0);
      chk($sformatf("bp_rel_in_ready_%0d", i), 163'(in_ready[i]), 163'd1);
      chk($sformatf("bp_rel_c_%0d", i), c[i], 163'hC9);
    end
    run_op(326'd1, 163'd1, 1'b0);

    // asynchronous reset during the third fold cycle
    a         = rand_wide();
    b         = rand_wide();
    d         = clmul(a, b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mid_rst_ov_%0d", i), 163'(out_valid[i]), 163'd0);
      chk($sformatf("mid_rst_c_%0d", i), c[i], 163'd0);
      chk($sformatf("mid_rst_in_ready_%0d", i), 163'(in_ready[i]), 163'd1);
      chk($sformatf("mid_rst_busy_%0d", i), 163'(busy[i]), 163'd0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = '0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      stale = stale | out_valid | busy;
    end
    chk("no_stale_after_rst", 163'(stale), 163'd0);
    run_op(326'd1 << 324, (163'd1 << 161) | 163'h1422, 1'b0);

    for (int n = 0; n < 200; n++) begin
      if (n % 2 == 0) begin
        a = rand_wide();
        b = rand_wide();
        x = clmul(a, b);
      end else begin
        x = rand_wide();
      end
      run_op(x, ref_mod(x), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
